// File: rtl/pwm_width_controller.sv
// rtl/pwm_width_controller.sv - PWM width code sequencer with period-boundary updates
//
// Holds a requested 2-bit width code as a target and applies it to the PWM
// width register only on PWM period boundaries, so a pulse is never cut short
// or stretched mid-period. Drives the register's reset input until the first
// period boundary after reset.
//
// Optional feature macro: PWM_RAMP_EN
//   defined   - soft ramp, one code step every RAMP_PERIODS period strobes
//   undefined - jump straight to the target on the first period strobe
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          synchronous active-high reset
//   width_up_i       one-cycle request: target + 1
//   width_down_i     one-cycle request: target - 1
//   width_load_i     one-cycle request: target = width_value_i
//   width_value_i    code used by width_load_i
//   period_end_i     one-cycle strobe from the PWM counter at period wrap
//   pwm_width_o      active width code to the register
//   register_reset_o reset input of the width register
//   update_busy_o    high while the active code differs from the target
//   update_done_o    one-cycle pulse when the active code reaches the target
//   limit_hit_o      one-cycle pulse on a saturated up/down request

module pwm_width_controller #(
    parameter int RAMP_PERIODS = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       width_up_i,
    input  logic       width_down_i,
    input  logic       width_load_i,
    input  logic [1:0] width_value_i,
    input  logic       period_end_i,
    output logic [1:0] pwm_width_o,
    output logic       register_reset_o,
    output logic       update_busy_o,
    output logic       update_done_o,
    output logic       limit_hit_o
);

    if (RAMP_PERIODS < 1) begin : g_bad_ramp_periods
        $error("RAMP_PERIODS must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_STEADY  = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [1:0] pwm_q, pwm_d;
    logic       reg_reset_q, reg_reset_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       limit_q, limit_d;

`ifdef PWM_RAMP_EN
    localparam int CW = $clog2(RAMP_PERIODS + 1);
    localparam logic [CW-1:0] RAMP_MAX = CW'(RAMP_PERIODS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    pwm_step;

    assign cnt_inc = cnt_q + 1'b1;

    // Step direction is taken from the pre-edge target; no step if already equal.
    always_comb begin
        pwm_step = pwm_q;
        if (target_q > pwm_q) begin
            pwm_step = pwm_q + 2'd1;
        end else if (target_q < pwm_q) begin
            pwm_step = pwm_q - 2'd1;
        end
    end
`endif

    // Request decode: load beats up beats down; up+down together cancel out.
    always_comb begin
        target_d = target_q;
        limit_d  = 1'b0;
        if (width_load_i) begin
            target_d = width_value_i;
        end else if (width_up_i && !width_down_i) begin
            if (target_q == 2'b11) begin
                limit_d = 1'b1;
            end else begin
                target_d = target_q + 2'd1;
            end
        end else if (width_down_i && !width_up_i) begin
            if (target_q == 2'b00) begin
                limit_d = 1'b1;
            end else begin
                target_d = target_q - 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pwm_d       = pwm_q;
        reg_reset_d = reg_reset_q;
        done_d      = 1'b0;
`ifdef PWM_RAMP_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_INIT: begin
                reg_reset_d = 1'b1;
                pwm_d       = 2'b00;
                if (period_end_i) begin
                    reg_reset_d = 1'b0;
                    state_d     = (target_q == 2'b00) ? ST_STEADY : ST_PENDING;
`ifdef PWM_RAMP_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_STEADY: begin
                // Compare the post-edge target so busy rises the cycle after a request.
                if (target_d != pwm_q) begin
                    state_d = ST_PENDING;
`ifdef PWM_RAMP_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_PENDING: begin
`ifdef PWM_RAMP_EN
                if (period_end_i && (cnt_inc == RAMP_MAX)) begin
                    cnt_d = '0;
                    pwm_d = pwm_step;
                    if (pwm_step == target_d) begin
                        state_d = ST_STEADY;
                        done_d  = 1'b1;
                    end
                end else begin
                    if (period_end_i) begin
                        cnt_d = cnt_inc;
                    end
                    // Target came back to the active code: nothing left to apply.
                    if (target_d == pwm_q) begin
                        state_d = ST_STEADY;
                    end
                end
`else
                if (period_end_i) begin
                    pwm_d = target_q;
                    // A request in the same cycle moves the target again; keep pending.
                    if (target_d == target_q) begin
                        state_d = ST_STEADY;
                        done_d  = 1'b1;
                    end
                end else if (target_d == pwm_q) begin
                    state_d = ST_STEADY;
                end
`endif
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        busy_d = (state_d == ST_PENDING);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_INIT;
            target_q    <= 2'b00;
            pwm_q       <= 2'b00;
            reg_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            limit_q     <= 1'b0;
`ifdef PWM_RAMP_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            pwm_q       <= pwm_d;
            reg_reset_q <= reg_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            limit_q     <= limit_d;
`ifdef PWM_RAMP_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign pwm_width_o      = pwm_q;
    assign register_reset_o = reg_reset_q;
    assign update_busy_o    = busy_q;
    assign update_done_o    = done_q;
    assign limit_hit_o      = limit_q;

endmodule

// File: tb/tb_pwm_width_controller.sv
// tb/tb_pwm_width_controller.sv - table-driven checks for pwm_width_controller

module tb_pwm_width_controller;

    logic       clk;
    logic       rst;
    logic       up;
    logic       down;
    logic       load;
    logic [1:0] value;
    logic       pe;
    logic [1:0] pwm;
    logic       rr;
    logic       busy;
    logic       done;
    logic       limit;

    int tests;
    int fails;

    typedef struct {
        logic       up;
        logic       down;
        logic       load;
        logic [1:0] value;
        logic       pe;
        logic [1:0] pwm;
        logic       rr;
        logic       busy;
        logic       done;
        logic       limit;
    } vec_t;

    vec_t vq[$];

    pwm_width_controller #(
        .RAMP_PERIODS(2)
    ) dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .width_up_i      (up),
        .width_down_i    (down),
        .width_load_i    (load),
        .width_value_i   (value),
        .period_end_i    (pe),
        .pwm_width_o     (pwm),
        .register_reset_o(rr),
        .update_busy_o   (busy),
        .update_done_o   (done),
        .limit_hit_o     (limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic u, logic d, logic l, logic [1:0] v, logic p,
                                logic [1:0] ew, logic er, logic eb, logic ed, logic el);
        vec_t t;
        t.up = u; t.down = d; t.load = l; t.value = v; t.pe = p;
        t.pwm = ew; t.rr = er; t.busy = eb; t.done = ed; t.limit = el;
        return t;
    endfunction

    task automatic check(string name, logic [1:0] ew, logic er, logic eb, logic ed, logic el);
        tests++;
        if (pwm !== ew || rr !== er || busy !== eb || done !== ed || limit !== el) begin
            fails++;
            $display("FAIL %s: got pwm=%0d rr=%b busy=%b done=%b limit=%b, expected pwm=%0d rr=%b busy=%b done=%b limit=%b",
                     name, pwm, rr, busy, done, limit, ew, er, eb, ed, el);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(vec_t t, string name);
        up = t.up; down = t.down; load = t.load; value = t.value; pe = t.pe;
        @(posedge clk);
        #1;
        check(name, t.pwm, t.rr, t.busy, t.done, t.limit);
    endtask

    task automatic idle_inputs();
        up = 1'b0; down = 1'b0; load = 1'b0; value = 2'b00; pe = 1'b0;
    endtask

    logic [1:0] cur;

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        rst = 1'b1;

        // Start-up: reset two cycles, period strobe at cycle 6.
        vq.push_back(mk(0,0,0,2'd0,0, 2'd0,1,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd0,1,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd0,1,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd0,1,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd0,0,0,0,0));
`ifdef PWM_RAMP_EN
        // Soft ramp with two strobes per step, load 11 from 00.
        vq.push_back(mk(0,0,1,2'd3,0, 2'd0,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd0,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd0,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd1,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd1,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd2,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd2,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd3,0,0,1,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd3,0,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd3,0,0,0,0));
        cur = 2'd3;
`else
        // Two ups, applied on the next strobe.
        vq.push_back(mk(1,0,0,2'd0,0, 2'd0,0,1,0,0));
        vq.push_back(mk(1,0,0,2'd0,0, 2'd0,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd0,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd2,0,0,1,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd2,0,0,0,0));
        // Load 11, saturated up, up+down cancel.
        vq.push_back(mk(0,0,1,2'd3,0, 2'd2,0,1,0,0));
        vq.push_back(mk(1,0,0,2'd0,0, 2'd2,0,1,0,1));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd2,0,1,0,0));
        vq.push_back(mk(1,1,0,2'd0,0, 2'd2,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd3,0,0,1,0));
        vq.push_back(mk(1,0,0,2'd0,0, 2'd3,0,0,0,1));
        vq.push_back(mk(0,0,1,2'd3,0, 2'd3,0,0,0,0));
        // Two downs to 01.
        vq.push_back(mk(0,1,0,2'd0,0, 2'd3,0,1,0,0));
        vq.push_back(mk(0,1,0,2'd0,0, 2'd3,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd1,0,0,1,0));
        // Up coincident with the strobe waits a full period.
        vq.push_back(mk(1,0,0,2'd0,1, 2'd1,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd1,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd2,0,0,1,0));
        vq.push_back(mk(0,0,0,2'd0,0, 2'd2,0,0,0,0));
        // Target returns to the active code: back to steady, no done.
        vq.push_back(mk(1,0,0,2'd0,0, 2'd2,0,1,0,0));
        vq.push_back(mk(0,1,0,2'd0,0, 2'd2,0,0,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd2,0,0,0,0));
        // Saturated down at 00, load beats up.
        vq.push_back(mk(0,0,1,2'd0,0, 2'd2,0,1,0,0));
        vq.push_back(mk(0,1,0,2'd0,0, 2'd2,0,1,0,1));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd0,0,0,1,0));
        vq.push_back(mk(0,1,0,2'd0,0, 2'd0,0,0,0,1));
        vq.push_back(mk(1,0,1,2'd1,0, 2'd0,0,1,0,0));
        vq.push_back(mk(0,0,0,2'd0,1, 2'd1,0,0,1,0));
        cur = 2'd1;
`endif

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", 2'd0, 1, 0, 0, 0);

        foreach (vq[i]) begin
            apply(vq[i], $sformatf("row%0d", i));
        end

        // Reset while a change is pending discards it.
        idle_inputs();
        load = 1'b1;
        value = ~cur;
        @(posedge clk);
        #1;
        check("pending_before_reset", cur, 0, 1, 0, 0);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_mid_pending", 2'd0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check("init_after_reset", 2'd0, 1, 0, 0, 0);
        pe = 1'b1;
        @(posedge clk);
        #1;
        pe = 1'b0;
        check("init_exit_steady", 2'd0, 0, 0, 0, 0);
        pe = 1'b1;
        @(posedge clk);
        #1;
        pe = 1'b0;
        check("no_stale_change", 2'd0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
